// File: rtl/vec_wb_arbiter.sv
// Vector writeback arbiter: two requesters (vector ALU = 0, vector load unit = 1)
// compete for a single register-file write port through one registered output slot.
//
// mux2vec: lane-wise 2:1 vector multiplexer.
//   sel  - 0 selects in0, 1 selects in1
//   in0  - vector input 0 (DEPTH lanes of WIDTH bits)
//   in1  - vector input 1
//   out  - selected vector
//
// vec_wb_arbiter:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   req0_valid/ready/addr/data - requester 0 (vector ALU) writeback handshake
//   req1_valid/ready/addr/data - requester 1 (vector load unit) writeback handshake
//   wb_stall                   - register file cannot take a write this cycle
//   wb_en/addr/data/src        - registered writeback beat and owning requester index

module mux2vec #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] in0 [0:DEPTH-1],
  input  logic [WIDTH-1:0] in1 [0:DEPTH-1],
  output logic [WIDTH-1:0] out [0:DEPTH-1]
);

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      out[i] = sel ? in1[i] : in0[i];
    end
  end

endmodule

module vec_wb_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [AW-1:0]    req0_addr,
  input  logic [WIDTH-1:0] req0_data [0:DEPTH-1],
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [AW-1:0]    req1_addr,
  input  logic [WIDTH-1:0] req1_data [0:DEPTH-1],
  input  logic             wb_stall,
  output logic             wb_en,
  output logic [AW-1:0]    wb_addr,
  output logic [WIDTH-1:0] wb_data [0:DEPTH-1],
  output logic             wb_src
);

  typedef enum logic {
    StEmpty,
    StFull
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] data_q [0:DEPTH-1];
  logic [WIDTH-1:0] data_d [0:DEPTH-1];
  logic             src_q, src_d;
  logic             last_grant_q, last_grant_d;

  logic             accept;
  logic             grant;
  logic             handshake;
  logic [WIDTH-1:0] mux_out [0:DEPTH-1];

  // Grant and handshake. The slot can be refilled when empty, or when full and the
  // held beat is being written this cycle. Gating with rst_n keeps ready low in reset.
  always_comb begin
    accept = (state_q == StEmpty) || !wb_stall;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else begin
      grant = req1_valid;
    end
    handshake  = rst_n && accept && (req0_valid || req1_valid);
    req0_ready = handshake && !grant;
    req1_ready = handshake && grant;
  end

  mux2vec #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mux (
    .sel (grant),
    .in0 (req0_data),
    .in1 (req1_data),
    .out (mux_out)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    src_d        = src_q;
    last_grant_d = last_grant_q;
    if (handshake) begin
      state_d      = StFull;
      addr_d       = grant ? req1_addr : req0_addr;
      data_d       = mux_out;
      src_d        = grant;
      last_grant_d = grant;
    end else if (accept) begin
      // Held beat (if any) drains this cycle with nothing to replace it.
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StEmpty;
      addr_q       <= '0;
      src_q        <= 1'b0;
      last_grant_q <= 1'b1;  // requester 0 wins the first tie
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      src_q        <= src_d;
      last_grant_q <= last_grant_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  always_comb begin
    wb_en   = (state_q == StFull);
    wb_addr = addr_q;
    wb_src  = src_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      wb_data[i] = data_q[i];
    end
  end

endmodule

// File: tb/tb_vec_wb_arbiter.sv
// Scoreboard bench for vec_wb_arbiter: stimulus pushes expected writeback beats,
// a negedge monitor pops one per completed write (wb_en high, no stall).
module tb_vec_wb_arbiter;

  localparam int W = 32;
  localparam int D = 4;
  localparam int A = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [A-1:0] req0_addr, req1_addr, wb_addr;
  logic [W-1:0] req0_data [0:D-1];
  logic [W-1:0] req1_data [0:D-1];
  logic [W-1:0] wb_data [0:D-1];
  logic         wb_stall, wb_en, wb_src;

  always #5 clk = ~clk;

  vec_wb_arbiter #(
    .WIDTH (W),
    .DEPTH (D),
    .AW    (A)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .wb_stall   (wb_stall),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .wb_src     (wb_src)
  );

  typedef struct packed {
    logic [A-1:0]        addr;
    logic [D-1:0][W-1:0] data;
    logic                src;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [A-1:0] a, input int base, input logic s);
    beat_t b;
    b.addr = a;
    b.src  = s;
    for (int i = 0; i < D; i++) b.data[i] = W'(base + i);
    exp_q.push_back(b);
  endtask

  // Lane i of each requester carries base + i.
  task automatic drive(input logic v0, input logic [A-1:0] a0, input int b0,
                       input logic v1, input logic [A-1:0] a1, input int b1,
                       input logic st);
    req0_valid = v0;
    req0_addr  = a0;
    req1_valid = v1;
    req1_addr  = a1;
    wb_stall   = st;
    for (int i = 0; i < D; i++) begin
      req0_data[i] = W'(b0 + i);
      req1_data[i] = W'(b1 + i);
    end
  endtask

  task automatic idle();
    drive(1'b0, '0, 0, 1'b0, '0, 0, 1'b0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ready(input string tag, input logic e0, input logic e1);
    #2;
    check({tag, "_req0_ready"}, 64'(req0_ready), 64'(e0));
    check({tag, "_req1_ready"}, 64'(req1_ready), 64'(e1));
  endtask

  // Monitor: one pop per write actually issued to the register file.
  always @(negedge clk) begin : monitor
    beat_t b;
    if (rst_n === 1'b1 && wb_en === 1'b1 && wb_stall === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_beat: got addr %0h src %0b, expected no write", wb_addr,
                 wb_src);
      end else begin
        b = exp_q.pop_front();
        check("wb_addr", 64'(wb_addr), 64'(b.addr));
        check("wb_src", 64'(wb_src), 64'(b.src));
        for (int i = 0; i < D; i++) begin
          check($sformatf("wb_data[%0d]", i), 64'(wb_data[i]), 64'(b.data[i]));
        end
      end
    end
  end

  initial begin
    // Reset with both requesters valid: nothing may be accepted.
    drive(1'b1, 4'd1, 0, 1'b1, 4'd2, 4, 1'b0);
    #1 rst_n = 1'b0;
    #2;
    check("rst_req0_ready", 64'(req0_ready), 64'd0);
    check("rst_req1_ready", 64'(req1_ready), 64'd0);
    check("rst_wb_en", 64'(wb_en), 64'd0);
    check("rst_wb_addr", 64'(wb_addr), 64'd0);
    check("rst_wb_src", 64'(wb_src), 64'd0);
    for (int i = 0; i < D; i++) check($sformatf("rst_wb_data[%0d]", i), 64'(wb_data[i]), 64'd0);
    idle();
    repeat (2) cyc();
    rst_n = 1'b1;

    // Single request from requester 0, one-cycle latency to wb_en.
    drive(1'b1, 4'd3, 0, 1'b0, '0, 0, 1'b0);
    chk_ready("single0", 1'b1, 1'b0);
    push(4'd3, 0, 1'b0);
    cyc();
    idle();
    #2 check("single0_wb_en", 64'(wb_en), 64'd1);
    cyc();
    #2 check("single0_drain_wb_en", 64'(wb_en), 64'd0);

    // Fresh reset, then both valid for 4 cycles: grants 0,1,0,1 back to back.
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    drive(1'b1, 4'd1, 0, 1'b1, 4'd2, 4, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk_ready($sformatf("rr%0d", k), (k % 2) == 0, (k % 2) == 1);
      if (k % 2 == 0) push(4'd1, 0, 1'b0);
      else push(4'd2, 4, 1'b1);
      if (k > 0) check($sformatf("rr%0d_wb_en", k), 64'(wb_en), 64'd1);
      cyc();
    end
    idle();
    #2 check("rr_last_wb_en", 64'(wb_en), 64'd1);
    cyc();
    #2 check("rr_drain_wb_en", 64'(wb_en), 64'd0);

    // Pointer favours req0 (last grant 1), only req1 valid: req1 wins at once.
    cyc();
    drive(1'b0, '0, 0, 1'b1, 4'd5, 8, 1'b0);
    chk_ready("only1", 1'b0, 1'b1);
    push(4'd5, 8, 1'b1);
    cyc();
    // Three stalled cycles with both valid: beat frozen, nothing accepted.
    drive(1'b1, 4'd6, 12, 1'b1, 4'd7, 16, 1'b1);
    for (int k = 0; k < 3; k++) begin
      chk_ready($sformatf("stall%0d", k), 1'b0, 1'b0);
      check($sformatf("stall%0d_wb_en", k), 64'(wb_en), 64'd1);
      check($sformatf("stall%0d_wb_addr", k), 64'(wb_addr), 64'd5);
      check($sformatf("stall%0d_wb_src", k), 64'(wb_src), 64'd1);
      check($sformatf("stall%0d_wb_data0", k), 64'(wb_data[0]), 64'd8);
      cyc();
    end
    // Stall released: req0 takes the next grant.
    drive(1'b1, 4'd6, 12, 1'b1, 4'd7, 16, 1'b0);
    chk_ready("release", 1'b1, 1'b0);
    push(4'd6, 12, 1'b0);
    cyc();
    // Requester changes data after its handshake; held beat must not follow.
    drive(1'b0, 4'd15, 200, 1'b0, 4'd15, 300, 1'b0);
    #2 check("hold_wb_addr", 64'(wb_addr), 64'd6);
    cyc();
    #2 check("release_drain_wb_en", 64'(wb_en), 64'd0);

    // Reset pulsed mid-stall while full: beat discarded, no write afterwards.
    cyc();
    drive(1'b1, 4'd9, 20, 1'b0, '0, 0, 1'b0);
    chk_ready("prerst", 1'b1, 1'b0);
    cyc();
    drive(1'b1, 4'd9, 20, 1'b0, '0, 0, 1'b1);
    #2 check("prerst_wb_en", 64'(wb_en), 64'd1);
    rst_n = 1'b0;
    #1;
    check("asyncrst_wb_en", 64'(wb_en), 64'd0);
    check("asyncrst_req0_ready", 64'(req0_ready), 64'd0);
    cyc();
    idle();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #2 check($sformatf("postrst%0d_wb_en", k), 64'(wb_en), 64'd0);
      cyc();
    end

    // Same destination from both: two separate writes in grant order.
    drive(1'b1, 4'd4, 24, 1'b1, 4'd4, 28, 1'b0);
    chk_ready("same0", 1'b1, 1'b0);
    push(4'd4, 24, 1'b0);
    cyc();
    chk_ready("same1", 1'b0, 1'b1);
    push(4'd4, 28, 1'b1);
    cyc();
    idle();
    repeat (3) cyc();

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
